arb3_rr: RTL and testbench

ARB3_RR -- requirements
Module: arb3_rr

---
 rtl/arb3_pkg.sv | 21 ++
 rtl/arb3_rr_mux3.sv | 21 ++
 rtl/arb3_rr.sv | 121 ++++++++++++
 tb/tb_arb3_rr.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/arb3_pkg.sv
// Shared definitions for the 3-way round-robin packet arbiter.
package arb3_pkg;

    localparam int NREQ = 3;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    // First requester after 'last' in circular order; returns 'last' when none request.
    function automatic logic [1:0] rr_pick(input logic [1:0] last, input logic [NREQ-1:0] valid);
        int idx;
        rr_pick = last;
        for (int k = NREQ; k >= 1; k--) begin
            idx = (int'(last) + k) % NREQ;
            if (valid[idx]) rr_pick = 2'(idx);
        end
    endfunction

endpackage

// File: rtl/arb3_rr_mux3.sv
// Three-input data mux; select values outside 0..2 yield zero.
module arb3_rr_mux3 #(
    parameter int WIREWIDTH = 1
) (
    input  logic [1:0]         sel,
    input  logic [WIREWIDTH:0] d0,
    input  logic [WIREWIDTH:0] d1,
    input  logic [WIREWIDTH:0] d2,
    output logic [WIREWIDTH:0] y
);

    always_comb begin
        case (sel)
            2'd0:    y = d0;
            2'd1:    y = d1;
            2'd2:    y = d2;
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/arb3_rr.sv
// Round-robin packet arbiter for three requesters with a registered output beat.
//
// state | meaning
// IDLE  | no grant held; arbitrate among req_valid starting after last winner
// BUSY  | grant held by requester s until its last beat transfers
module arb3_rr
    import arb3_pkg::*;
#(
    parameter int WIREWIDTH = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ-1:0]      req_last,
    input  logic [WIREWIDTH:0]   d0,
    input  logic [WIREWIDTH:0]   d1,
    input  logic [WIREWIDTH:0]   d2,
    output logic [NREQ-1:0]      req_ready,
    output logic                 out_valid,
    output logic                 out_last,
    output logic [WIREWIDTH:0]   o,
    input  logic                 out_ready,
    output logic [1:0]           s,
    output logic                 busy
);

    state_e               state_q, state_d;
    logic [1:0]           s_q, s_d;
    logic [1:0]           last_q, last_d;
    logic                 out_valid_q, out_valid_d;
    logic                 out_last_q, out_last_d;
    logic [WIREWIDTH:0]   o_q, o_d;
    logic [WIREWIDTH:0]   mux_y;
    logic                 grant_ready;
    logic                 xfer;
    logic                 xfer_last;

    arb3_rr_mux3 #(
        .WIREWIDTH (WIREWIDTH)
    ) u_mux (
        .sel (s_q),
        .d0  (d0),
        .d1  (d1),
        .d2  (d2),
        .y   (mux_y)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            s_q         <= 2'd0;
            last_q      <= 2'd2;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            o_q         <= '0;
        end else begin
            state_q     <= state_d;
            s_q         <= s_d;
            last_q      <= last_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            o_q         <= o_d;
        end
    end

    // The output register can take a new beat when empty or being drained this cycle.
    assign grant_ready = !out_valid_q || out_ready;

    always_comb begin
        req_ready = '0;
        busy      = 1'b0;
        if (state_q == BUSY) begin
            busy = 1'b1;
            for (int i = 0; i < NREQ; i++) begin
                if (s_q == 2'(i)) req_ready[i] = grant_ready;
            end
        end
    end

    // Only the granted bit of req_ready can be set, so these reductions select requester s.
    assign xfer      = |(req_valid & req_ready);
    assign xfer_last = |(req_valid & req_ready & req_last);

    always_comb begin
        state_d     = state_q;
        s_d         = s_q;
        last_d      = last_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        o_d         = o_q;

        if (out_valid_q && out_ready) out_valid_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (|req_valid) begin
                    s_d     = rr_pick(last_q, req_valid);
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (xfer) begin
                    o_d         = mux_y;
                    out_last_d  = xfer_last;
                    out_valid_d = 1'b1;
                    if (xfer_last) begin
                        last_d  = s_q;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign o         = o_q;
    assign s         = s_q;

endmodule

// File: tb/tb_arb3_rr.sv
// Self-checking bench for arb3_rr: behavioural round-robin model plus directed literal checks.
module tb_arb3_rr;

    localparam int W = 3;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [2:0]   req_valid = '0;
    logic [2:0]   req_last = '0;
    logic [W:0]   d0 = '0, d1 = '0, d2 = '0;
    logic [2:0]   req_ready;
    logic         out_valid, out_last, out_ready = 1'b0;
    logic [W:0]   o;
    logic [1:0]   s;
    logic         busy;

    int n_pass = 0;
    int n_tot  = 0;
    bit cmp_en = 1'b0;

    arb3_rr #(.WIREWIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_last  (req_last),
        .d0        (d0),
        .d1        (d1),
        .d2        (d2),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_last  (out_last),
        .o         (o),
        .out_ready (out_ready),
        .s         (s),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_tot++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Behavioural model: a packet owner (or none), the previous winner, and a one-entry output slot.
    bit         m_busy;
    int         m_g;
    int         m_last;
    bit         m_ov, m_ol;
    logic [W:0] m_o;

    function automatic logic [W:0] data_of(input int i);
        return (i == 0) ? d0 : (i == 1) ? d1 : d2;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy = 0; m_g = 0; m_last = 2; m_ov = 0; m_ol = 0; m_o = '0;
        end else begin
            bit drained;
            bit slot_free;
            drained   = m_ov && out_ready;
            slot_free = !m_ov || out_ready;
            if (!m_busy) begin
                for (int k = 1; k <= 3; k++) begin
                    if (req_valid[(m_last + k) % 3]) begin
                        m_g = (m_last + k) % 3;
                        m_busy = 1;
                        break;
                    end
                end
                if (drained) m_ov = 0;
            end else if (req_valid[m_g] && slot_free) begin
                m_o  = data_of(m_g);
                m_ol = req_last[m_g];
                m_ov = 1;
                if (req_last[m_g]) begin
                    m_last = m_g;
                    m_busy = 0;
                end
            end else if (drained) begin
                m_ov = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && cmp_en) begin
            int exp_rdy;
            exp_rdy = (m_busy && (!m_ov || out_ready)) ? (1 << m_g) : 0;
            chk("req_ready", int'(req_ready), exp_rdy);
            chk("busy", int'(busy), int'(m_busy));
            chk("s", int'(s), m_g);
            chk("out_valid", int'(out_valid), int'(m_ov));
            chk("out_last", int'(out_last), int'(m_ol));
            chk("o", int'(o), int'(m_o));
        end
    end

    task automatic do_reset();
        rst_n = 1'b0;
        req_valid = '0; req_last = '0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
    endtask

    task automatic drive(input logic [2:0] v, input logic [2:0] l, input logic r);
        @(posedge clk);
        #1;
        req_valid = v; req_last = l; out_ready = r;
    endtask

    task automatic rand_drive();
        @(posedge clk);
        #1;
        req_valid = 3'($urandom_range(0, 7));
        for (int i = 0; i < 3; i++) req_last[i] = ($urandom_range(0, 3) == 0);
        out_ready = ($urandom_range(0, 3) != 0);
        d0 = (W+1)'($urandom); d1 = (W+1)'($urandom); d2 = (W+1)'($urandom);
    endtask

    // Hold a multi-beat packet with a stalled output, then reset asynchronously mid-cycle.
    task automatic rst_mid();
        drive(3'b111, 3'b000, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("pre_rst_busy", int'(busy), 1);
        chk("pre_rst_ov", int'(out_valid), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_ov", int'(out_valid), 0);
        chk("rst_ol", int'(out_last), 0);
        chk("rst_o", int'(o), 0);
        chk("rst_rdy", int'(req_ready), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_s", int'(s), 0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("post_rst_s", int'(s), 0);
        chk("post_rst_busy", int'(busy), 1);
        chk("post_rst_ov", int'(out_valid), 0);
    endtask

    initial begin
        logic [W:0] beats[$];
        int         grants[$];
        int         seq_o[4];
        int         seq_g[4];
        seq_o = '{1, 2, 3, 1};
        seq_g = '{0, 1, 2, 0};

        do_reset();
        #1;
        chk("reset_s", int'(s), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_ov", int'(out_valid), 0);
        chk("reset_rdy", int'(req_ready), 0);
        cmp_en = 1'b1;

        // All requesting, single-beat packets: rotation 0,1,2,0.
        d0 = 1; d1 = 2; d2 = 3;
        drive(3'b111, 3'b111, 1'b1);
        for (int c = 0; c < 40 && beats.size() < 4; c++) begin
            @(negedge clk);
            if (req_ready != 0) grants.push_back(int'(s));
            if (out_valid) beats.push_back(o);
        end
        chk("rr_beats_seen", beats.size() >= 4 ? 1 : 0, 1);
        for (int i = 0; i < 4; i++) begin
            if (i < beats.size())  chk("rr_o_order", int'(beats[i]), seq_o[i]);
            if (i < grants.size()) chk("rr_grant_order", grants[i], seq_g[i]);
        end

        // Lone request from requester 2: ready one cycle later, output the cycle after.
        do_reset();
        d2 = 5;
        drive(3'b100, 3'b100, 1'b1);
        @(negedge clk);
        chk("lat_rdy_n", int'(req_ready), 0);
        @(negedge clk);
        chk("lat_rdy_n1", int'(req_ready), 4);
        chk("lat_s", int'(s), 2);
        drive(3'b000, 3'b000, 1'b1);
        @(negedge clk);
        chk("lat_ov_n2", int'(out_valid), 1);
        chk("lat_o_n2", int'(o), 5);

        for (int c = 0; c < 3000; c++) begin
            if (c % 600 == 300) rst_mid();
            else rand_drive();
        end

        cmp_en = 1'b0;
        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
